axi_lite_mst: RTL
=================

// Module: axi_lite_mst
// PURPOSE
//  Bridge from the core's simple valid/ready memory-request port to an AXI4-Lite master (AW/W/AR/R only).
//  No B channel, matching our peripheral slaves: a write completes when AW and W have both handshaked.
//  Drives sysio-class slaves and any other AXI4-Lite slave on the peripheral bus.
//  One transaction outstanding; the response is held until the core accepts it.
// PARAMETERS
//  ADDR_W  32  address width (matches MemAddrBus)
//  DATA_W  32  data width (matches MemBus); strobe width is DATA_W/8
// PORTS
//  clk            in   1         single clock, rising edge
//  rst            in   1         synchronous reset, active high
//  req_valid_i    in   1         core request valid
//  req_ready_o    out  1         request accepted this cycle
//  req_we_i       in   1         1 = write, 0 = read
//  req_addr_i     in   ADDR_W    byte address, forwarded unaltered
//  req_wdata_i    in   DATA_W    write data
//  req_sel_i      in   DATA_W/8  byte strobes (ignored for reads)
//  rsp_valid_o    out  1         response valid
//  rsp_ready_i    in   1         core takes the response
//  rsp_we_o       out  1         response is a write ack
//  rsp_rdata_o    out  DATA_W    read data (0 for write acks)
//  m_axi_awaddr/awvalid out, awready in; m_axi_wdata/wstrb/wvalid out, wready in
//  m_axi_araddr/arvalid out, arready in; m_axi_rdata/rvalid in, rready out
// BEHAVIOUR
//  Reset: state=IDLE; every valid output and rready=0; rsp_we_o=0; rsp_rdata_o=0.
//   Address/data regs are 0. Reset is taken on any cycle, mid-transaction included.
//   The slave shares rst, so no orphan handshakes remain.
//  req_ready_o = (state==IDLE) | (state==RESP & rsp_ready_i) (combinational). Accept = req_valid_i & req_ready_o.
//   On accept, latch addr/wdata/sel/we.
//  States:
//   IDLE: on accept -> WR (we=1) or RA (we=0).
//   WR: awvalid and wvalid both high. Track aw_done and w_done separately.
//    Each valid drops the cycle after its own ready is seen. Both valids are held stable until then.
//    When both are done (in the same or different cycles) -> RESP with rsp_we_o=1 and rsp_rdata_o=0.
//   RA: arvalid high until arready -> RD. araddr is held stable.
//   RD: rready=1. On rvalid, capture rdata -> RESP with rsp_we_o=0.
//   RESP: rsp_valid_o=1; outputs stable until rsp_ready_i.
//    rsp_ready_i & new accept -> WR/RA directly (back-to-back). rsp_ready_i with no new request -> IDLE.
//  Latency, with slave readies asserted combinationally:
//   accept at T, awvalid/arvalid at T+1.
//   Write: rsp_valid at T+2.
//   Read: rvalid at T+2, rsp_valid at T+3.
//  rready is never high outside RD. An rvalid arriving in any other state is a protocol error (assert in sim).
//  A write with sel=0000 is still issued on the bus.
//  The master never withdraws a valid before its ready.
// STRUCTURE
//  State encodings (IDLE/WR/RA/RD/RESP) and MemAddrBus/MemBus go in defines.v as shared `defines.
//  Single module; no sub-module. Registers: state, aw_done, w_done, latched request, response.
// TESTING
//  1. Write 0x4000_0F00 / 0xDEADBEEF / sel=1111, slave readies tied high.
//     -> awvalid=wvalid=1 at T+1 only; rsp_valid=1 and rsp_we=1 at T+2.
//  2. Read 0x4000_0404, slave returns 0x0000_00A5 one cycle after arready.
//     -> rsp_rdata=0x000000A5 at T+3, rsp_we=0.
//  3. Write with wready 3 cycles after awready.
//     -> awvalid drops after 1 cycle, wvalid is held 4 cycles, one rsp only after W completes.
//  4. Hold rsp_ready_i=0 for 5 cycles, then back-to-back read after write.
//     -> rsp stable for 5 cycles; req_ready=1 only on the rsp_ready cycle; arvalid the next cycle.
//  5. Assert rst in WR with awvalid=1.
//     -> the next cycle has all valids 0, state IDLE, req_ready=1; a following read completes normally.
//  6. 1000 random read/write transactions against a sysio-style slave model with random ready delays.
//     -> read data matches the model; no valid deasserts before ready.

Source files
------------

// File: rtl/axi_lite_mst_pkg.sv
// Shared widths and state encoding for the core-to-AXI4-Lite master bridge.
package axi_lite_mst_pkg;

  localparam int unsigned MemAddrW = 32;
  localparam int unsigned MemDataW = 32;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRa,
    StRd,
    StResp
  } state_e;

endpackage

// File: rtl/axi_lite_mst.sv
// Core valid/ready request port to AXI4-Lite master (AW/W/AR/R, no B channel).
// One transaction outstanding; the response is held until the core takes it.
module axi_lite_mst
  import axi_lite_mst_pkg::*;
#(
  parameter int unsigned ADDR_W = MemAddrW,
  parameter int unsigned DATA_W = MemDataW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_we_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  state_e              state_q;
  logic                aw_done_q, w_done_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] sel_q;
  logic                awvalid_q, wvalid_q, arvalid_q, rready_q;
  logic                rsp_valid_q, rsp_we_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic accept, aw_fire, w_fire, aw_ok, w_ok;

  assign req_ready_o = (state_q == StIdle) | ((state_q == StResp) & rsp_ready_i);
  assign accept      = req_valid_i & req_ready_o;
  assign aw_fire     = awvalid_q & m_axi_awready;
  assign w_fire      = wvalid_q & m_axi_wready;
  // A channel counts as complete in the cycle its handshake happens.
  assign aw_ok       = aw_done_q | aw_fire;
  assign w_ok        = w_done_q | w_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        StWr: begin
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_fire) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= 1'b1;
            rsp_rdata_q <= '0;
          end
        end
        StRa: begin
          if (arvalid_q && m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRd;
          end
        end
        StRd: begin
          if (m_axi_rvalid) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= m_axi_rdata;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: ;
      endcase

      // Accept overrides the RESP->IDLE step so back-to-back requests skip IDLE.
      if (accept) begin
        addr_q      <= req_addr_i;
        wdata_q     <= req_wdata_i;
        sel_q       <= req_sel_i;
        aw_done_q   <= 1'b0;
        w_done_q    <= 1'b0;
        rsp_valid_q <= 1'b0;
        if (req_we_i) begin
          state_q   <= StWr;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
        end else begin
          state_q   <= StRa;
          arvalid_q <= 1'b1;
        end
      end
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = sel_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_we_o      = rsp_we_q;
  assign rsp_rdata_o   = rsp_rdata_q;

  rvalid_only_in_rd: assert property (@(posedge clk) disable iff (rst)
    m_axi_rvalid |-> (state_q == StRd));

endmodule
